// File: rtl/tdm_mixer_if.sv
// tdm_mixer_if: bundles the sample clock, voice product bus, mixing controls
// and the mixed-sample outputs of tdm_mixer into one interface.
//   master : the environment side.
//            Drives:   main_clk, products, enable_mask, gain_shift.
//            Receives: sample_out, sample_valid, busy, clip, overrun,
//                      dbg_state.
//   slave  : the mixer side, with every direction reversed.
// Handshake: there is no back-pressure. sample_valid is a one-cycle strobe;
// the consumer must capture sample_out and clip in that cycle. Between
// strobes, sample_out and clip hold the last delivered values.
interface tdm_mixer_if #(
    parameter int C_WIDTH   = 32,
    parameter int NUM_UNITS = 32,
    parameter int OUT_WIDTH = 24
);
    logic                           main_clk;
    logic [C_WIDTH*NUM_UNITS-1:0]   products;
    logic [NUM_UNITS-1:0]           enable_mask;
    logic [4:0]                     gain_shift;
    logic [OUT_WIDTH-1:0]           sample_out;
    logic                           sample_valid;
    logic                           busy;
    logic                           clip;
    logic                           overrun;
    logic [1:0]                     dbg_state;

    modport master (
        output main_clk, products, enable_mask, gain_shift,
        input  sample_out, sample_valid, busy, clip, overrun, dbg_state
    );

    modport slave (
        input  main_clk, products, enable_mask, gain_shift,
        output sample_out, sample_valid, busy, clip, overrun, dbg_state
    );
endinterface

// File: rtl/tdm_mixer.sv
// tdm_mixer: voice mixer for the TDM multiplier.
// On each rising edge of main_clk, the mixer snapshots the product bus and
// the enable mask. It then adds the enabled voices one per clk_in cycle
// into a wide signed accumulator. The sum is scaled by an arithmetic right
// shift of gain_shift, saturated to OUT_WIDTH, and delivered with a
// one-cycle sample_valid strobe.
// Ports:
//   clk_in : control clock; all logic runs on its rising edge.
//   reset  : synchronous, active-low.
//   bus    : tdm_mixer_if slave modport.
//     Inputs:  main_clk, products, enable_mask, gain_shift.
//     Outputs: sample_out, sample_valid, busy, clip, overrun, dbg_state.
module tdm_mixer #(
    parameter int C_WIDTH   = 32,
    parameter int NUM_UNITS = 32,
    parameter int OUT_WIDTH = 24
) (
    input  logic         clk_in,
    input  logic         reset,
    tdm_mixer_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_UNITS);
    // One guard bit per doubling of the voice count, so the sum cannot
    // overflow.
    localparam int ACC_W = C_WIDTH + IDX_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCALE = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                         state_q;
    logic                           main_d_q;
    logic [C_WIDTH*NUM_UNITS-1:0]   snap_q;
    logic [NUM_UNITS-1:0]           mask_q;
    logic signed [ACC_W-1:0]        acc_q;
    logic [IDX_W-1:0]               idx_q;
    logic [OUT_WIDTH-1:0]           result_q;
    logic                           clip_n_q;
    logic [OUT_WIDTH-1:0]           sample_out_q;
    logic                           sample_valid_q;
    logic                           clip_q;
    logic                           overrun_q;

    logic                           rise;
    logic signed [C_WIDTH-1:0]      voice;
    logic signed [ACC_W-1:0]        voice_ext;
    logic signed [ACC_W-1:0]        acc_d;
    logic signed [ACC_W-1:0]        scaled;
    logic [OUT_WIDTH-1:0]           result_d;
    logic                           clip_d;

    // main_d_q resets high, so a main_clk that is already high when reset
    // releases is not treated as a new sample edge.
    assign rise = bus.main_clk & ~main_d_q;

    always_comb begin
        voice     = snap_q[C_WIDTH*int'(idx_q) +: C_WIDTH];
        voice_ext = mask_q[idx_q] ? {{IDX_W{voice[C_WIDTH-1]}}, voice} : '0;
        acc_d     = acc_q + voice_ext;
        scaled    = acc_q >>> bus.gain_shift;
        result_d  = scaled[OUT_WIDTH-1:0];
        clip_d    = 1'b0;
        if (scaled > SAT_MAX) begin
            result_d = SAT_MAX[OUT_WIDTH-1:0];
            clip_d   = 1'b1;
        end else if (scaled < SAT_MIN) begin
            result_d = SAT_MIN[OUT_WIDTH-1:0];
            clip_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            main_d_q       <= 1'b1;
            snap_q         <= '0;
            mask_q         <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            result_q       <= '0;
            clip_n_q       <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            clip_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            main_d_q       <= bus.main_clk;
            sample_valid_q <= 1'b0;

            // A sample edge outside IDLE is lost; the mix in progress
            // continues. The flag is sticky until reset.
            if (rise && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        snap_q  <= bus.products;
                        mask_q  <= bus.enable_mask;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_UNITS-1)) begin
                        state_q <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    result_q <= result_d;
                    clip_n_q <= clip_d;
                    state_q  <= S_OUT;
                end
                S_OUT: begin
                    sample_out_q   <= result_q;
                    clip_q         <= clip_n_q;
                    sample_valid_q <= 1'b1;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.clip         = clip_q;
    assign bus.overrun      = overrun_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_tdm_mixer.sv
module tb_tdm_mixer;
    localparam int C_WIDTH   = 16;
    localparam int NUM_UNITS = 4;
    localparam int OUT_WIDTH = 8;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    tdm_mixer_if #(.C_WIDTH(C_WIDTH), .NUM_UNITS(NUM_UNITS), .OUT_WIDTH(OUT_WIDTH)) bus ();

    tdm_mixer #(.C_WIDTH(C_WIDTH), .NUM_UNITS(NUM_UNITS), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    // Clock and reset
    always #5 clk_in = ~clk_in;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk_in);
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] v0, input logic [15:0] v1,
                                          input logic [15:0] v2, input logic [15:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    // Driver: launches one mix with its rise at posedge T.
    // Observation covers the eight edges T+0..T+7 (k = 0..7).
    //   zero_at   : products are cleared after edge T+zero_at.
    //   rerise_at : an extra main_clk rise lands at edge T+rerise_at.
    // The task only records what it observes. The caller does the checks.
    task automatic do_mix(input logic [63:0] prods, input logic [3:0] mask,
                          input logic [4:0] gain, input int zero_at, input int rerise_at,
                          output logic [7:0] got_out, output logic got_clip,
                          output int strobe_k, output int strobes, output int busy_err);
        bus.products    = prods;
        bus.enable_mask = mask;
        bus.gain_shift  = gain;
        if (bus.main_clk) begin
            bus.main_clk = 1'b0;
            tick();
        end
        bus.main_clk = 1'b1;
        strobe_k = -1;
        strobes  = 0;
        busy_err = 0;
        got_out  = 'x;
        got_clip = 1'bx;
        for (int k = 0; k <= 7; k++) begin
            tick();
            if (k == 0) bus.main_clk = 1'b0;
            if (bus.sample_valid === 1'b1) begin
                strobes++;
                if (strobe_k < 0) begin
                    strobe_k = k;
                    got_out  = bus.sample_out;
                    got_clip = bus.clip;
                end
            end
            if (k <= 6 && bus.busy !== (k <= 5)) busy_err++;
            if (k == zero_at) bus.products = '0;
            if (k + 1 == rerise_at) bus.main_clk = 1'b1;
            if (k == rerise_at) bus.main_clk = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.main_clk = 1'b0;
        bus.products = '0;
        bus.enable_mask = '0;
        bus.gain_shift = '0;
        repeat (3) tick();
        n_checks++;
        if ({bus.sample_out, bus.sample_valid, bus.busy, bus.clip, bus.overrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h v=%b busy=%b clip=%b ovr=%b, expected all 0",
                     bus.sample_out, bus.sample_valid, bus.busy, bus.clip, bus.overrun);
        end
        n_checks++;
        if (bus.dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", bus.dbg_state);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_sum();
        logic [7:0] o; logic c; int sk, ns, be;
        do_mix(pack4(16'sd10, 16'sd20, 16'sd30, 16'sd40), 4'b1111, 5'd0, -1, -1, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h64 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_out: got %h clip %b expected 64 clip 0", o, c);
        end
        n_checks++;
        if (sk !== 6 || ns !== 1) begin
            n_fail++;
            $display("FAIL basic_strobe: got edge %0d count %0d expected edge 6 count 1", sk, ns);
        end
        n_checks++;
        if (be !== 0) begin
            n_fail++;
            $display("FAIL basic_busy: got %0d bad cycles expected 0", be);
        end
    endtask

    task automatic test_sign_scale();
        logic [7:0] o; logic c; int sk, ns, be;
        do_mix(pack4(-16'sd100, -16'sd100, -16'sd100, -16'sd100), 4'b1111, 5'd2, -1, -1,
               o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h9C || c !== 1'b0 || sk !== 6) begin
            n_fail++;
            $display("FAIL sign_scale: got %h clip %b edge %0d expected 9c clip 0 edge 6", o, c, sk);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] o; logic c; int sk, ns, be;
        do_mix(pack4(16'sd100, 16'sd100, 16'sd100, 16'sd100), 4'b1111, 5'd0, -1, -1, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h7F || c !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos: got %h clip %b expected 7f clip 1", o, c);
        end
        do_mix(pack4(-16'sd200, -16'sd200, -16'sd200, -16'sd200), 4'b1111, 5'd0, -1, -1,
               o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h80 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg: got %h clip %b expected 80 clip 1", o, c);
        end
        repeat (3) tick();
        n_checks++;
        if (bus.sample_out !== 8'h80 || bus.clip !== 1'b1 || bus.sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hold: got %h clip %b valid %b expected 80 clip 1 valid 0",
                     bus.sample_out, bus.clip, bus.sample_valid);
        end
        do_mix(pack4(16'sd1, 16'sd1, 16'sd1, 16'sd1), 4'b1111, 5'd0, -1, -1, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h04 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: got %h clip %b expected 04 clip 0", o, c);
        end
    endtask

    task automatic test_mask_snapshot();
        logic [7:0] o; logic c; int sk, ns, be;
        do_mix(pack4(16'sd10, 16'sd20, 16'sd30, 16'sd40), 4'b0101, 5'd0, 2, -1, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h28 || c !== 1'b0 || sk !== 6) begin
            n_fail++;
            $display("FAIL mask_snapshot: got %h clip %b edge %0d expected 28 clip 0 edge 6", o, c, sk);
        end
    endtask

    // Second rise at T+7: the minimum sample period, which must be accepted.
    task automatic test_back_to_back();
        logic [7:0] o; logic c; int sk, ns, be;
        int sk2;
        do_mix(pack4(16'sd10, 16'sd20, 16'sd30, 16'sd40), 4'b1111, 5'd0, 6, 7, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h64 || sk !== 6 || ns !== 1) begin
            n_fail++;
            $display("FAIL b2b_first: got %h edge %0d count %0d expected 64 edge 6 count 1", o, sk, ns);
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy %b expected 1", bus.busy);
        end
        sk2 = -1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (bus.sample_valid === 1'b1 && sk2 < 0) begin
                sk2 = j;
                o = bus.sample_out;
            end
        end
        n_checks++;
        if (sk2 !== 6 || o !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_second: got %h edge %0d expected 00 edge 6", o, sk2);
        end
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overrun: got %b expected 0", bus.overrun);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] o; logic c; int sk, ns, be;
        do_mix(pack4(16'sd10, 16'sd20, 16'sd30, 16'sd40), 4'b1111, 5'd0, -1, 3, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h64 || sk !== 6 || ns !== 1 || be !== 0) begin
            n_fail++;
            $display("FAIL ovr_mix: got %h edge %0d count %0d busyerr %0d expected 64 6 1 0",
                     o, sk, ns, be);
        end
        n_checks++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_flag: got %b expected 1", bus.overrun);
        end
        do_mix(pack4(-16'sd50, 16'sd20, 16'sd5, 16'sd1), 4'b1111, 5'd0, -1, -1, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'hE8 || c !== 1'b0 || sk !== 6) begin
            n_fail++;
            $display("FAIL ovr_next: got %h clip %b edge %0d expected e8 clip 0 edge 6", o, c, sk);
        end
        n_checks++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got %b expected 1", bus.overrun);
        end
    endtask

    task automatic test_reset_mid_mix();
        logic [7:0] o; logic c; int sk, ns, be;
        int nv, nb;
        bus.products    = pack4(16'sd10, 16'sd20, 16'sd30, 16'sd40);
        bus.enable_mask = 4'b1111;
        bus.gain_shift  = 5'd0;
        bus.main_clk    = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if ({bus.sample_out, bus.sample_valid, bus.busy, bus.clip, bus.overrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got out=%h v=%b busy=%b clip=%b ovr=%b, expected all 0",
                     bus.sample_out, bus.sample_valid, bus.busy, bus.clip, bus.overrun);
        end
        nv = 0;
        nb = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (bus.sample_valid !== 1'b0) nv++;
            if (bus.busy !== 1'b0) nb++;
        end
        n_checks++;
        if (nv !== 0 || nb !== 0) begin
            n_fail++;
            $display("FAIL rst_no_trigger: got %0d valid %0d busy cycles expected 0 0", nv, nb);
        end
        do_mix(pack4(16'sd10, 16'sd20, 16'sd30, 16'sd40), 4'b1111, 5'd0, -1, -1, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h64 || sk !== 6 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_recover: got %h edge %0d ovr %b expected 64 edge 6 ovr 0",
                     o, sk, bus.overrun);
        end
    endtask

    // A rise on the edge that delivers the sample is dropped.
    task automatic test_out_edge_overrun();
        logic [7:0] o; logic c; int sk, ns, be;
        do_mix(pack4(16'sd10, 16'sd20, 16'sd30, 16'sd40), 4'b1111, 5'd0, -1, 6, o, c, sk, ns, be);
        n_checks++;
        if (o !== 8'h64 || sk !== 6 || bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL out_edge: got %h edge %0d ovr %b expected 64 edge 6 ovr 1",
                     o, sk, bus.overrun);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL out_edge_idle: got busy %b state %0d expected 0 0",
                     bus.busy, bus.dbg_state);
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_sign_scale();
        test_saturation();
        test_mask_snapshot();
        test_back_to_back();
        test_overrun();
        test_reset_mid_mix();
        test_out_edge_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
